// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, load/store type codes, default address limit.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [2:0] ST_SW  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SB  = 3'b010;

  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_0FFF;

endpackage

// File: rtl/dm_req_check.sv
// Legality check of one memory request.
// Range, alignment and access-type validity.
module dm_req_check
  import dm_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [2:0]  lstype_i,
  output logic        legal_o
);

  // Start legal, clear on any violated rule
  always_comb begin
    legal_o = 1'b1;
    if (addr_i > ADDR_LIMIT) begin
      legal_o = 1'b0;
    end
    if (we_i) begin
      case (lstype_i)
        ST_SW:   if (addr_i[1:0] != 2'b00) legal_o = 1'b0;
        ST_SH:   if (addr_i[0]) legal_o = 1'b0;
        ST_SB:   ;
        default: legal_o = 1'b0;
      endcase
    end else begin
      case (lstype_i)
        LD_LW:   if (addr_i[1:0] != 2'b00) legal_o = 1'b0;
        LD_LH,
        LD_LHU:  if (addr_i[0]) legal_o = 1'b0;
        LD_LB,
        LD_LBU:  ;
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single data memory.
// IDLE -> ACCESS -> RESP, round-robin on contention.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  lstype0,
  input  logic [2:0]  lstype1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [2:0]  dm_lstype,
  input  logic [31:0] dm_rd
);

  state_e      state_q;
  logic        ptr_q;
  logic        id_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [2:0]  lst_q;
  logic        bad_q;
  logic        done0_q, done1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata_q;

  logic        win_d;
  logic [31:0] w_addr_d;
  logic [31:0] w_wd_d;
  logic        w_we_d;
  logic [2:0]  w_lst_d;
  logic        legal_d;
  logic        acc_ok_d;

  // Pick the winner and mux its payload
  always_comb begin
    win_d    = (req0 && req1) ? ptr_q : req1;
    w_addr_d = win_d ? addr1   : addr0;
    w_wd_d   = win_d ? wdata1  : wdata0;
    w_we_d   = win_d ? we1     : we0;
    w_lst_d  = win_d ? lstype1 : lstype0;
  end

  dm_req_check #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_check (
    .addr_i  (w_addr_d),
    .we_i    (w_we_d),
    .lstype_i(w_lst_d),
    .legal_o (legal_d)
  );

  // Memory is driven only in a legal ACCESS cycle; reset kills it at once
  always_comb begin
    acc_ok_d  = (state_q == S_ACCESS) && !bad_q && !Reset;
    dm_we     = acc_ok_d && we_q;
    dm_addr   = acc_ok_d ? addr_q : '0;
    dm_wd     = acc_ok_d ? wd_q   : '0;
    dm_lstype = acc_ok_d ? lst_q  : '0;
  end

  // Arbitration FSM with registered responses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      lst_q   <= '0;
      bad_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            id_q    <= win_d;
            ptr_q   <= ~win_d;
            addr_q  <= w_addr_d;
            wd_q    <= w_wd_d;
            we_q    <= w_we_d;
            lst_q   <= w_lst_d;
            bad_q   <= ~legal_d;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q <= (!bad_q && !we_q) ? dm_rd : '0;
          done0_q <= ~id_q;
          done1_q <= id_q;
          err0_q  <= ~id_q & bad_q;
          err1_q  <= id_q & bad_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory.
// Inputs driven #1 after rising edges, outputs checked there too.
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        we0, we1;
  logic [2:0]  lstype0, lstype1;
  logic        done0, done1;
  logic        err0, err1;
  logic [31:0] rdata;
  logic [31:0] dm_addr, dm_wd;
  logic        dm_we;
  logic [2:0]  dm_lstype;
  logic [31:0] dm_rd;

  logic [31:0] mem [0:1023];
  logic [31:0] dm_word;
  logic [15:0] dm_half;
  logic [7:0]  dm_byte;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  dm_arbiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .we0      (we0),
    .we1      (we1),
    .lstype0  (lstype0),
    .lstype1  (lstype1),
    .done0    (done0),
    .done1    (done1),
    .err0     (err0),
    .err1     (err1),
    .rdata    (rdata),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_we    (dm_we),
    .dm_lstype(dm_lstype),
    .dm_rd    (dm_rd)
  );

  // Combinational memory read with load extension
  always_comb begin
    dm_word = mem[dm_addr[11:2]];
    dm_half = dm_addr[1] ? dm_word[31:16] : dm_word[15:0];
    dm_byte = dm_word[8*dm_addr[1:0] +: 8];
    case (dm_lstype)
      3'b001:  dm_rd = {{16{dm_half[15]}}, dm_half};
      3'b010:  dm_rd = {16'h0, dm_half};
      3'b011:  dm_rd = {{24{dm_byte[7]}}, dm_byte};
      3'b100:  dm_rd = {24'h0, dm_byte};
      default: dm_rd = dm_word;
    endcase
  end

  // Synchronous memory write
  always @(posedge Clk) begin
    if (dm_we) begin
      case (dm_lstype)
        3'b001:  mem[dm_addr[11:2]][16*dm_addr[1] +: 16] <= dm_wd[15:0];
        3'b010:  mem[dm_addr[11:2]][8*dm_addr[1:0] +: 8] <= dm_wd[7:0];
        default: mem[dm_addr[11:2]] <= dm_wd;
      endcase
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit p, logic [31:0] a, logic [31:0] wd,
                       bit w, logic [2:0] lt);
    if (p) begin
      req1 = 1'b1; addr1 = a; wdata1 = wd; we1 = w; lstype1 = lt;
    end else begin
      req0 = 1'b1; addr0 = a; wdata0 = wd; we0 = w; lstype0 = lt;
    end
  endtask

  task automatic txn(string tag, bit p, logic [31:0] a, logic [31:0] wd,
                     bit w, logic [2:0] lt, bit exp_err,
                     logic [31:0] exp_rd);
    drive(p, a, wd, w, lt);
    tick();
    chk({tag, ".dm_we"}, {31'b0, dm_we}, {31'b0, w && !exp_err});
    chk({tag, ".dm_addr"}, dm_addr, exp_err ? 32'h0 : a);
    tick();
    chk({tag, ".done"}, {30'b0, done1, done0}, p ? 32'd2 : 32'd1);
    chk({tag, ".err"}, {30'b0, err1, err0},
        exp_err ? (p ? 32'd2 : 32'd1) : 32'd0);
    chk({tag, ".rdata"}, rdata, exp_rd);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk({tag, ".idle"}, {30'b0, done1, done0}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[8]    = 32'h8A00_1234;
    mem[1023] = 32'hCAFE_F00D;
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    we0 = 1'b0; we1 = 1'b0; lstype0 = '0; lstype1 = '0;
    tick();
    tick();
    chk("rst.done", {30'b0, done1, done0}, 32'd0);
    chk("rst.err", {30'b0, err1, err0}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.dm", dm_addr | dm_wd | {29'b0, dm_lstype}, 32'd0);
    chk("rst.dm_we", {31'b0, dm_we}, 32'd0);
    Reset = 1'b0;
    tick();

    txn("p0_sw", 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 3'b000, 1'b0, 32'h0);
    chk("p0_sw.mem", mem[4], 32'hDEAD_BEEF);
    txn("p0_lw", 1'b0, 32'h10, 32'h0, 1'b0, 3'b000, 1'b0, 32'hDEAD_BEEF);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b0, 32'h10, 32'h0, 1'b0, 3'b000);
    drive(1'b1, 32'h13, 32'h0, 1'b0, 3'b100);
    tick();
    chk("both.acc0", dm_addr, 32'h10);
    tick();
    chk("both.done0", {30'b0, done1, done0}, 32'd1);
    chk("both.rd0", rdata, 32'hDEAD_BEEF);
    req0 = 1'b0;
    tick();
    tick();
    chk("both.acc1", dm_addr, 32'h13);
    tick();
    chk("both.done1", {30'b0, done1, done0}, 32'd2);
    chk("both.err1", {31'b0, err1}, 32'd0);
    chk("both.rd1", rdata, 32'h0000_00DE);
    req1 = 1'b0;
    tick();

    drive(1'b0, 32'h10, 32'h0, 1'b0, 3'b000);
    drive(1'b1, 32'h14, 32'h0, 1'b0, 3'b000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("rr.k%0d", k), {30'b0, done1, done0},
          {30'b0, (k == 5 || k == 11), (k == 2 || k == 8)});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    txn("p1_sh_mis", 1'b1, 32'h11, 32'hABCD, 1'b1, 3'b001, 1'b1, 32'h0);
    txn("p1_lw_oob", 1'b1, 32'h1000, 32'h0, 1'b0, 3'b000, 1'b1, 32'h0);
    txn("p0_badlt", 1'b0, 32'h0, 32'h0, 1'b0, 3'b101, 1'b1, 32'h0);
    txn("p0_lw_top", 1'b0, 32'hFFC, 32'h0, 1'b0, 3'b000, 1'b0,
        32'hCAFE_F00D);

    drive(1'b0, 32'h20, 32'h1111_1111, 1'b1, 3'b000);
    tick();
    Reset = 1'b1;
    #1;
    chk("rstacc.dm_we", {31'b0, dm_we}, 32'd0);
    tick();
    chk("rstacc.done", {30'b0, done1, done0}, 32'd0);
    chk("rstacc.err", {30'b0, err1, err0}, 32'd0);
    chk("rstacc.rdata", rdata, 32'd0);
    chk("rstacc.dm", dm_addr | dm_wd | {28'b0, dm_we, dm_lstype}, 32'd0);
    chk("rstacc.mem", mem[8], 32'h8A00_1234);
    req0 = 1'b0;
    Reset = 1'b0;
    tick();

    txn("sb", 1'b0, 32'h22, 32'h55, 1'b1, 3'b010, 1'b0, 32'h0);
    chk("sb.mem", mem[8], 32'h8A55_1234);
    txn("lb", 1'b0, 32'h22, 32'h0, 1'b0, 3'b011, 1'b0, 32'h0000_0055);
    txn("lh", 1'b0, 32'h22, 32'h0, 1'b0, 3'b001, 1'b0, 32'hFFFF_8A55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_0FFF, highest legal byte address; requests above it are rejected.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  request from port 0 (CPU) / port 1 (DMA); held high with stable payload until matching done.
REQ-005 addr0 / addr1  input  32 each  byte address.
REQ-006 wdata0 / wdata1  input  32 each  store data, right-aligned.
REQ-007 we0 / we1  input  1 each  1 = store, 0 = load.
REQ-008 lstype0 / lstype1  input  3 each  access type; loads 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; stores 000 sw, 001 sh, 010 sb.
REQ-009 done0 / done1  output  1 each  one-cycle completion pulse to the owning port.
REQ-010 err0 / err1  output  1 each  valid with done; 1 = request rejected.
REQ-011 rdata  output  32  load result; valid while either done is high.
REQ-012 dm_addr / dm_wd  output  32 each  DM address and write data.
REQ-013 dm_we  output  1  DM write enable.
REQ-014 dm_lstype  output  3  DM access type.
REQ-015 dm_rd  input  32  DM combinational read data.

Function
REQ-016 States: IDLE, ACCESS, RESP.
REQ-017 IDLE: if any req is high, latch the winner's payload and id, evaluate legality, go to ACCESS; otherwise stay.
REQ-018 Winner: the only requester if one is high; if both are high, the port named by the priority pointer.
REQ-019 Pointer: set to the non-winning port on each grant, so it alternates under contention.
REQ-020 Illegal: address > ADDR_LIMIT; lw/sw with addr[1:0] != 0; lh/lhu/sh with addr[0] != 0; load lstype 101-111; store lstype 011-111.
REQ-021 ACCESS, legal request: drive dm_addr, dm_wd and dm_lstype from the latched payload; dm_we = latched we for exactly this cycle; capture dm_rd into rdata for a load, 0 for a store; go to RESP.
REQ-022 ACCESS, illegal request: dm_we = 0; rdata = 0; err flag latched; go to RESP.
REQ-023 RESP: raise done and err of the latched port for one cycle; rdata held; go to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N; DM accessed at N+1; done at N+2; throughput is one access per 3 cycles.
REQ-025 The requester drops req on the edge that ends RESP; a req still high in IDLE counts as a new request.
REQ-026 Outside ACCESS, dm_we = 0 and dm_addr, dm_wd, dm_lstype = 0.
REQ-027 A new req arriving in ACCESS or RESP is ignored until IDLE; no request is lost while it stays asserted.
REQ-028 Done is never asserted to both ports in the same cycle.

Reset
REQ-029 Reset high at a rising edge forces IDLE, pointer = port 0, done0/1 = 0, err0/1 = 0, rdata = 0 and all dm_* outputs = 0.
REQ-030 Reset mid-ACCESS aborts the transaction: dm_we = 0 in that cycle, no done is issued, and the requester must re-request.
REQ-031 Reset dominates req in the same cycle.

Structure
REQ-032 Package dm_arb_pkg holds the state enum, the LStype load/store constants and the ADDR_LIMIT default.
REQ-033 One combinational sub-module, dm_req_check, takes addr, we and lstype and outputs legal; it is instantiated once, on the winner's payload.

Verification
REQ-034 Port 0 only: sw 0x0000_0010, data 0xDEADBEEF, then lw 0x10 -> done0 at N+2 with err0 = 0, then rdata = 0xDEADBEEF.
REQ-035 Both ports request at once, reset pointer, port 0 lw 0x10, port 1 lbu 0x13 -> port 0 done first; port 1 done 3 cycles later with rdata 0x0000_00DE.
REQ-036 Both ports hold req continuously for 12 cycles -> done alternates 0,1,0,1 at 3-cycle spacing.
REQ-037 Port 1 sh at 0x0000_0011, then lw 0x0000_1000 -> each gives done1 with err1 = 1, dm_we never high, rdata = 0.
REQ-038 Reset raised in the ACCESS cycle of a port 0 sw to 0x20 -> no done0, word at 0x20 unchanged, all outputs 0 the next cycle.
REQ-039 sb 0x55 to 0x22, then lb 0x22 -> rdata 0x0000_0055; then lh 0x22 -> sign-extended upper half of the word.
